board_vram_arbiter: RTL

//  Shares one single-port synchronous board RAM between the VGA renderer and two game-logic writers.
//  - Renderer: cursor, cell codes.
//  - Writers: move FSM on port 0, cursor/reset logic on port 1.
//  - Display reads own every pixel-tick cycle from the sync generator.
//  - Writers take the remaining cycles via round-robin req/ack.
//  - Sits between vga_sync/renderer and the board RAM.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/board_vram_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the board VRAM arbiter.
//   arb_state_t : write-side FSM states
//   CELL_*      : board cell codes stored in the RAM
//   VRAM_AW/DW  : default RAM address/data widths
package vga_pkg;

  localparam int unsigned VRAM_AW = 4;
  localparam int unsigned VRAM_DW = 2;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick.
//   i_req0/i_req1 : request lines
//   i_rr          : port favoured on a tie
//   o_winner      : chosen port (0 or 1), meaningful only when o_any=1
//   o_any         : at least one request present
module rr_arbiter2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr,
  output logic o_winner,
  output logic o_any
);

  always_comb begin
    o_any = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_winner = i_rr;
    end else begin
      o_winner = i_req1;
    end
  end

endmodule

// File: rtl/board_vram_arbiter.sv
// Shares one single-port synchronous board RAM between the VGA renderer (reads on every
// pixel tick) and two game-logic writers (round-robin req/ack on the remaining cycles).
// Ports:
//   i_clk, i_reset                 : clock, asynchronous active-high reset
//   i_p_tick, i_video_on           : timing from vga_sync
//   i_disp_addr / o_disp_data,
//   o_disp_valid                   : renderer read port (2-cycle latency from p_tick)
//   i_req*/i_addr*/i_wdata*/o_ack* : writer ports 0 and 1
//   o_ram_we/addr/wdata, i_ram_rdata : board RAM interface
//   o_busy                         : write FSM not idle
// Build option: VRAM_ARB_BLANK_ONLY_EN restricts writes to blanking (video_on=0).
module board_vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW,
  parameter int unsigned DW = VRAM_DW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_p_tick,
  input  logic          i_video_on,
  input  logic [AW-1:0] i_disp_addr,
  output logic [DW-1:0] o_disp_data,
  output logic          o_disp_valid,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_ack0,
  output logic          o_ack1,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_busy
);

  arb_state_t    r_state;
  logic          r_rr;
  logic          r_winner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_rd_pend;
  logic          r_disp_valid;
  logic [DW-1:0] r_disp_data;

  logic w_win_open;
  logic w_winner;
  logic w_any;
  logic w_write_fire;

`ifdef VRAM_ARB_BLANK_ONLY_EN
  // Writes only while the beam is blanked so the board never changes mid-frame.
  assign w_win_open = ~i_video_on;
`else
  logic w_unused_video_on;
  assign w_unused_video_on = i_video_on;
  assign w_win_open        = 1'b1;
`endif

  rr_arbiter2 u_rr (
    .i_req0   (i_req0),
    .i_req1   (i_req1),
    .i_rr     (r_rr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // The pixel-tick read slot always wins the RAM port.
  assign w_write_fire = (r_state == WRITE) && !i_p_tick && w_win_open;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_rr     <= 1'b0;
      r_winner <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_win_open && w_any) begin
            r_winner <= w_winner;
            r_addr   <= w_winner ? i_addr1 : i_addr0;
            r_wdata  <= w_winner ? i_wdata1 : i_wdata0;
            r_state  <= WRITE;
          end
        end
        WRITE: begin
          if (w_write_fire) begin
            r_ack0  <= ~r_winner;
            r_ack1  <= r_winner;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_rr    <= ~r_winner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read pipeline: address in the p_tick cycle, RAM data one cycle later, registered out.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_pend    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_rd_pend    <= i_p_tick;
      r_disp_valid <= r_rd_pend;
      if (r_rd_pend) begin
        r_disp_data <= i_ram_rdata;
      end
    end
  end

  always_comb begin
    o_ram_we    = 1'b0;
    o_ram_addr  = r_addr;
    o_ram_wdata = r_wdata;
    if (i_p_tick) begin
      o_ram_addr = i_disp_addr;
    end else if (w_write_fire) begin
      o_ram_we = 1'b1;
    end
  end

  assign o_ack0       = r_ack0;
  assign o_ack1       = r_ack1;
  assign o_busy       = (r_state != IDLE);
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;

endmodule
